// File: rtl/gameconsole_pkg.sv
// Shared console-wide constants and types used by the VPU blocks.
package gameconsole_pkg;

   localparam int unsigned SCREEN_W_DEF  = 320;
   localparam int unsigned SCREEN_H_DEF  = 240;
   localparam int unsigned FB_ADDR_W_DEF = 17;

   typedef enum logic [1:0] {
      CapIdle,
      CapArmed,
      CapCapture,
      CapDrain
   } capture_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/vpu_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and show-ahead read data.
module vpu_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_wr, do_rd;

   // Full/empty come from the registered count only, so a same-cycle pop never frees a slot.
   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/vpu_frame_capture.sv
// Samples the VPU pixel stream, tracks x/y position and writes each visible pixel
// into a linear framebuffer through a small FIFO and a valid/ready write port.
module vpu_frame_capture
   import gameconsole_pkg::*;
#(
   parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H   = SCREEN_H_DEF,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned FB_ADDR_W  = FB_ADDR_W_DEF,
   parameter int unsigned FB_BASE    = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 continuous,
   input  logic                 dot_clk,
   input  logic [31:0]          color,
   input  logic                 hsync,
   input  logic                 vsync,
   output logic                 fb_wr_valid,
   input  logic                 fb_wr_ready,
   output logic [FB_ADDR_W-1:0] fb_wr_addr,
   output logic [31:0]          fb_wr_data,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overflow,
   output logic                 line_err,
   output logic [15:0]          drop_cnt
);

   localparam int unsigned XW = $clog2(SCREEN_W + 1);
   localparam int unsigned YW = $clog2(SCREEN_H + 2);
   localparam int unsigned EW = FB_ADDR_W + 32;

   capture_state_t       state_q, state_d;
   logic                 hsync_q, vsync_q;
   logic [XW-1:0]        x_q, x_d;
   logic [YW-1:0]        y_q, y_d;
   logic [FB_ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
   logic                 push_q, push_d;
   logic [EW-1:0]        push_data_q, push_data_d;
   logic                 overflow_q, overflow_d;
   logic                 line_err_q, line_err_d;
   logic [15:0]          drop_cnt_q, drop_cnt_d;

   logic                 fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic [EW-1:0]        fifo_rd_data;
   logic                 vsync_rise, vsync_fall, hsync_fall, sample;

   assign vsync_rise = vsync && !vsync_q;
   assign vsync_fall = !vsync && vsync_q;
   assign hsync_fall = !hsync && hsync_q;
   assign sample     = (state_q == CapCapture) && dot_clk && hsync && vsync;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      addr_d      = addr_q;
      base_d      = base_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      overflow_d  = overflow_q;
      line_err_d  = line_err_q;
      drop_cnt_d  = drop_cnt_q;
      fifo_wr     = 1'b0;
      frame_done  = 1'b0;

      // Second pipeline stage: the sample taken last cycle lands in the FIFO or is dropped.
      if (push_q) begin
         if (fifo_full) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc16(drop_cnt_q);
         end else begin
            fifo_wr = 1'b1;
         end
      end

      unique case (state_q)
         CapIdle: begin
            if (start) begin
               state_d    = CapArmed;
               overflow_d = 1'b0;
               line_err_d = 1'b0;
            end
         end
         CapArmed: begin
            if (vsync_rise) begin
               state_d    = CapCapture;
               x_d        = '0;
               y_d        = '0;
               addr_d     = FB_ADDR_W'(FB_BASE);
               base_d     = FB_ADDR_W'(FB_BASE);
               drop_cnt_d = '0;
            end
         end
         CapCapture: begin
            if (sample) begin
               if (x_q < XW'(SCREEN_W)) begin
                  push_d      = 1'b1;
                  push_data_d = {addr_q, color};
                  x_d         = x_q + XW'(1);
                  addr_d      = addr_q + FB_ADDR_W'(1);
               end else begin
                  line_err_d = 1'b1;
               end
            end
            if (hsync_fall) begin
               if (x_q != XW'(SCREEN_W)) line_err_d = 1'b1;
               // Empty lines do not count, so the line base follows y exactly.
               if (x_q != '0) begin
                  if (y_q != '1) y_d = y_q + YW'(1);
                  base_d = base_q + FB_ADDR_W'(SCREEN_W);
                  addr_d = base_q + FB_ADDR_W'(SCREEN_W);
               end
               x_d = '0;
            end
            if (vsync_fall) begin
               if (y_d != YW'(SCREEN_H)) line_err_d = 1'b1;
               state_d = CapDrain;
            end
         end
         CapDrain: begin
            if (fifo_empty && !push_q) begin
               frame_done = 1'b1;
               state_d    = continuous ? CapArmed : CapIdle;
            end
         end
         default: state_d = CapIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= CapIdle;
         hsync_q     <= 1'b0;
         vsync_q     <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         addr_q      <= '0;
         base_q      <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         overflow_q  <= 1'b0;
         line_err_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         hsync_q     <= hsync;
         vsync_q     <= vsync;
         x_q         <= x_d;
         y_q         <= y_d;
         addr_q      <= addr_d;
         base_q      <= base_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         overflow_q  <= overflow_d;
         line_err_q  <= line_err_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   vpu_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr),
      .wr_data (push_data_q),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign fb_wr_valid = !fifo_empty;
   assign fifo_rd     = fb_wr_valid && fb_wr_ready;
   assign fb_wr_addr  = fifo_rd_data[EW-1:32];
   assign fb_wr_data  = fifo_rd_data[31:0];
   assign busy        = (state_q != CapIdle);
   assign overflow    = overflow_q;
   assign line_err    = line_err_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_vpu_frame_capture.sv
// Scoreboard bench: stimulus pushes expected framebuffer writes, a monitor matches them.
module tb_vpu_frame_capture;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int AW = 17;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            seq;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n, start, continuous, dot_clk, hsync, vsync, fb_wr_ready;
   logic [31:0]   color;
   logic          fb_wr_valid, busy, frame_done, overflow, line_err;
   logic [AW-1:0] fb_wr_addr;
   logic [31:0]   fb_wr_data;
   logic [15:0]   drop_cnt;

   int errors = 0;
   int checks = 0;

   exp_t exp_q[$];
   int   m_x, m_y, m_seq;
   logic m_err, m_ovf;
   int   skipped, first_skip, wr_cnt, tot_wr, done_cnt, first_addr;
   logic cont_watch, busy_gap, rr_on;
   logic          stall_pend;
   logic [AW-1:0] stall_addr;
   logic [31:0]   stall_data;

   vpu_frame_capture #(
      .SCREEN_W   (W),
      .SCREEN_H   (H),
      .FIFO_DEPTH (16),
      .FB_ADDR_W  (AW),
      .FB_BASE    (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .continuous  (continuous),
      .dot_clk     (dot_clk),
      .color       (color),
      .hsync       (hsync),
      .vsync       (vsync),
      .fb_wr_valid (fb_wr_valid),
      .fb_wr_ready (fb_wr_ready),
      .fb_wr_addr  (fb_wr_addr),
      .fb_wr_data  (fb_wr_data),
      .busy        (busy),
      .frame_done  (frame_done),
      .overflow    (overflow),
      .line_err    (line_err),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on each write handshake; missing entries are drops.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_done) done_cnt++;
         if (cont_watch && !busy) busy_gap = 1'b1;
         if (stall_pend) begin
            checks++;
            if (!fb_wr_valid || fb_wr_addr !== stall_addr || fb_wr_data !== stall_data) begin
               errors++;
               $display("FAIL stall_stable: got v=%0b a=%0h d=%0h expected a=%0h d=%0h",
                        fb_wr_valid, fb_wr_addr, fb_wr_data, stall_addr, stall_data);
            end
         end
         if (fb_wr_valid && fb_wr_ready) begin
            exp_t e;
            if (wr_cnt == 0) first_addr = int'(fb_wr_addr);
            wr_cnt++;
            tot_wr++;
            while (exp_q.size() > 0 && exp_q[0].addr != fb_wr_addr) begin
               e = exp_q.pop_front();
               if (first_skip < 0) first_skip = e.seq;
               skipped++;
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL write_addr: got unexpected addr %0h", fb_wr_addr);
            end else begin
               e = exp_q.pop_front();
               if (e.data !== fb_wr_data) begin
                  errors++;
                  $display("FAIL write_data @%0h: got %0h expected %0h",
                           fb_wr_addr, fb_wr_data, e.data);
               end
            end
         end
         stall_pend = fb_wr_valid && !fb_wr_ready;
         stall_addr = fb_wr_addr;
         stall_data = fb_wr_data;
      end else begin
         stall_pend = 1'b0;
      end
   end

   task automatic pulse_start(input logic from_idle);
      if (from_idle) begin
         m_err = 1'b0;
         m_ovf = 1'b0;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic drive_pixel(input int gap);
      logic [31:0] c;
      c = $urandom;
      if (m_x < W) begin
         exp_q.push_back('{addr: AW'(m_y * W + m_x), data: c, seq: m_seq});
         m_seq++;
         m_x++;
      end else begin
         m_err = 1'b1;
      end
      dot_clk = 1'b1;
      color   = c;
      tick();
      dot_clk = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic end_line();
      hsync = 1'b0;
      if (m_x != W) m_err = 1'b1;
      if (m_x != 0) m_y++;
      m_x = 0;
      repeat (3) tick();
   endtask

   task automatic begin_frame();
      m_x = 0; m_y = 0; m_seq = 0;
      skipped = 0; first_skip = -1; wr_cnt = 0;
      vsync = 1'b1;
      repeat (3) tick();
   endtask

   task automatic drive_frame(input int l0, input int l1, input int l2, input int l3,
                              input int gap);
      int lens[4];
      lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
      begin_frame();
      for (int li = 0; li < 4; li++) begin
         hsync = 1'b1;
         tick();
         for (int p = 0; p < lens[li]; p++) drive_pixel(gap);
         end_line();
      end
      vsync = 1'b0;
      if (m_y != H) m_err = 1'b1;
      tick();
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 3000 && done_cnt < target; i++) tick();
      chk("frame_done_count", 64'(done_cnt), 64'(target));
      repeat (2) tick();
   endtask

   task automatic frame_checks(input string tag);
      skipped += exp_q.size();
      exp_q.delete();
      if (skipped > 0) m_ovf = 1'b1;
      chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(skipped));
      chk({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
      chk({tag, "_line_err"}, 64'(line_err), 64'(m_err));
      chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int done_ref, wr_ref;
      rst_n = 1'b0; start = 1'b0; continuous = 1'b0; dot_clk = 1'b0; color = '0;
      hsync = 1'b0; vsync = 1'b0; fb_wr_ready = 1'b1;
      done_cnt = 0; tot_wr = 0; wr_cnt = 0; skipped = 0; first_skip = -1; first_addr = -1;
      m_err = 1'b0; m_ovf = 1'b0; cont_watch = 1'b0; busy_gap = 1'b0; rr_on = 1'b0;
      stall_pend = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_valid", 64'(fb_wr_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(frame_done), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_line_err", 64'(line_err), 64'(0));
      chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
      rst_n = 1'b1;
      tick();

      // Nominal frame, always-ready sink
      pulse_start(1'b1);
      chk("armed_busy", 64'(busy), 64'(1));
      drive_frame(8, 8, 8, 8, 4);
      wait_done(1);
      chk("nom_writes", 64'(wr_cnt), 64'(32));
      chk("nom_first_addr", 64'(first_addr), 64'(0));
      frame_checks("nom");

      // Backpressure: sink stalled for 40 cycles, pixel every cycle
      pulse_start(1'b1);
      fb_wr_ready = 1'b0;
      fork
         begin
            repeat (40) tick();
            fb_wr_ready = 1'b1;
         end
      join_none
      drive_frame(8, 8, 8, 8, 1);
      wait_done(2);
      chk("bp_first_drop_seq", 64'(first_skip), 64'(16));
      chk("bp_writes", 64'(wr_cnt + skipped + exp_q.size()), 64'(32));
      frame_checks("bp");

      // Random backpressure
      pulse_start(1'b1);
      rr_on = 1'b1;
      fork
         begin
            while (rr_on) begin
               tick();
               fb_wr_ready = 1'($urandom_range(0, 1));
            end
            fb_wr_ready = 1'b1;
         end
      join_none
      drive_frame(8, 8, 8, 8, 2);
      rr_on = 1'b0;
      wait_done(3);
      frame_checks("rr");

      // Short line 2
      pulse_start(1'b1);
      drive_frame(8, 8, 7, 8, 3);
      wait_done(4);
      chk("short_writes", 64'(wr_cnt), 64'(31));
      frame_checks("short");

      // Long line 1
      pulse_start(1'b1);
      drive_frame(8, 10, 8, 8, 2);
      wait_done(5);
      chk("long_writes", 64'(wr_cnt), 64'(32));
      frame_checks("long");

      // Continuous over two frames
      continuous = 1'b1;
      pulse_start(1'b1);
      cont_watch = 1'b1;
      busy_gap = 1'b0;
      wr_ref = tot_wr;
      done_ref = done_cnt;
      drive_frame(8, 8, 8, 8, 2);
      repeat (8) tick();
      chk("cont_first_done", 64'(done_cnt), 64'(done_ref + 1));
      continuous = 1'b0;
      drive_frame(8, 8, 8, 8, 2);
      cont_watch = 1'b0;
      wait_done(done_ref + 2);
      chk("cont_writes", 64'(tot_wr - wr_ref), 64'(64));
      chk("cont_busy_held", 64'(busy_gap), 64'(0));
      frame_checks("cont");

      // Reset mid-line 1 while writes are pending
      pulse_start(1'b1);
      fb_wr_ready = 1'b0;
      begin_frame();
      hsync = 1'b1;
      tick();
      for (int p = 0; p < 8; p++) drive_pixel(1);
      end_line();
      hsync = 1'b1;
      tick();
      for (int p = 0; p < 3; p++) drive_pixel(1);
      chk("pre_rst_valid", 64'(fb_wr_valid), 64'(1));
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("mid_rst_valid", 64'(fb_wr_valid), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      hsync = 1'b0; vsync = 1'b0; fb_wr_ready = 1'b1;
      exp_q.delete();
      m_err = 1'b0; m_ovf = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", 64'(fb_wr_valid), 64'(0));
      done_ref = done_cnt;
      pulse_start(1'b1);
      drive_frame(8, 8, 8, 8, 4);
      wait_done(done_ref + 1);
      chk("rst_frame_writes", 64'(wr_cnt), 64'(32));
      chk("rst_frame_first_addr", 64'(first_addr), 64'(0));
      frame_checks("rstf");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vpu_frame_capture.md
# vpu_frame_capture

Receive-side counterpart of the VPU video output. It samples the `color` / `hsync` / `vsync` / `dot_clk` stream emitted by `vpu_core` and tracks the pixel position. Each visible pixel is written into a linear 32-bit framebuffer through a valid/ready write port, with a small FIFO in between. It is used for screenshot/readback and as the bridge to the scan-out framebuffer.

## Interface
Parameters:
- `SCREEN_W`, 320, visible pixels per line
- `SCREEN_H`, 240, visible lines per frame
- `FIFO_DEPTH`, 16, pixel FIFO entries; power of two, at least 4
- `FB_ADDR_W`, 17, framebuffer word-address width
- `FB_BASE`, 0, word address of pixel (0,0)

Ports (reset `rst_n`, synchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  one-cycle pulse; arms capture and clears the sticky flags
- `continuous`  in  1  when 1, re-arm automatically after each frame
- `dot_clk`  in  1  pixel strobe, one cycle high per pixel
- `color`  in  32  ARGB8888 pixel
- `hsync`  in  1  high while the line is in its visible region
- `vsync`  in  1  high while the frame is in its visible lines
- `fb_wr_valid`  out  1  write request
- `fb_wr_ready`  in  1  framebuffer accepts the write
- `fb_wr_addr`  out  FB_ADDR_W  word address
- `fb_wr_data`  out  32  pixel data
- `busy`  out  1  high in ARMED, CAPTURE and DRAIN
- `frame_done`  out  1  one-cycle pulse when a frame is fully written
- `overflow`  out  1  sticky; a pixel was dropped because the FIFO was full
- `line_err`  out  1  sticky; line length or line count did not match SCREEN_W / SCREEN_H
- `drop_cnt`  out  16  dropped pixels this frame; saturates at 0xFFFF

## Operation
- Reset values: state IDLE, FIFO empty, x=0, y=0, and every output 0.
- States:
  - IDLE: `start` -> ARMED.
  - ARMED: rising edge of `vsync` (registered compare) -> CAPTURE; x=0, y=0, `drop_cnt`=0.
  - CAPTURE: falling edge of `vsync` -> DRAIN.
  - DRAIN: when FIFO empty and no write outstanding, pulse `frame_done`, then go to ARMED if `continuous`, else IDLE.
- Sample condition: CAPTURE && `dot_clk` && `hsync` && `vsync`.
  - Each sample pushes {addr, color} into the FIFO.
  - x and addr advance even when the pixel is dropped, so later pixels still land at the correct address.
- Address: addr = FB_BASE + y*SCREEN_W + x.
  - Kept as an incremental counter; line base += SCREEN_W on each hsync falling edge.
  - No multiplier.
- Line end: on each `hsync` falling edge in CAPTURE:
  - if x != SCREEN_W, set `line_err`;
  - if x != 0, then y += 1;
  - then x = 0.
- Pixels with x >= SCREEN_W are not pushed. They set `line_err` and are not counted in `drop_cnt`.
- Frame end: at the `vsync` falling edge, set `line_err` if y != SCREEN_H.
- FIFO full at a sample: the pixel is dropped, `overflow` is set and `drop_cnt` increments. A pop in the same cycle does not free the slot (full comes from the registered count).
- `start` clears `overflow` and `line_err` only in IDLE. `start` in any other state is ignored.
- `rst_n` low mid-frame: everything is cleared immediately and no further writes are issued.
- `fb_wr_valid` is driven straight from FIFO not-empty.
- AXI-style handshake: once `fb_wr_valid` is asserted, `fb_wr_addr` and `fb_wr_data` stay stable until `fb_wr_ready`.

## Timing
- Sample at edge N -> FIFO write at edge N+1 -> `fb_wr_valid` high in the cycle after N+1 (latency 2).
- Throughput: one write per clock while `fb_wr_ready`=1.
- Sync edge detection uses the previous-cycle registered value, so state changes take effect 1 cycle after the input edge.
- `frame_done` is asserted in the cycle after the last write handshake of a DRAIN.
- If `vsync` rises while in DRAIN, that frame is not captured. ARMED needs a fresh rising edge.

## Structure
- `SCREEN_W`, `SCREEN_H` and `FB_ADDR_W` defaults come from `gameconsole_pkg`.
- The state enum `capture_state_t` is added to `gameconsole_pkg`.
- One sub-module, `vpu_sync_fifo`:
  - parameterised width and depth, registered count;
  - outputs `full`, `empty`, and show-ahead read data.
- Instanced with width FB_ADDR_W+32.

## Test plan
- Nominal frame with `dot_clk` every 4 cycles, SCREEN_W=8, SCREEN_H=4, always-ready sink -> exactly 32 writes at addresses 0..31 with data matching the stimulus, one `frame_done`, `line_err`=0.
- Backpressure: `fb_wr_ready` low for 40 cycles with FIFO_DEPTH=16 and a pixel every cycle -> `overflow`=1, `drop_cnt` = pixels sampled while full; surviving addresses correct; stable addr/data while stalled.
- Short line: line 2 carries 7 pixels -> `line_err`=1; line 3 starts at addr 24.
- Long line: 10 pixels -> pixels 8 and 9 are not written; `line_err`=1.
- `continuous`=1 over 2 frames -> 2 `frame_done` pulses; 64 writes; `busy` stays 1.
- `rst_n` low mid-line 1 -> next cycle `fb_wr_valid`=0 and state IDLE; a later `start` captures a clean frame from addr 0.
